// File: rtl/hazard_pkg.sv
// Shared types and codes for the pipeline hazard controller.
package hazard_pkg;

    // WDSel encoding for "write-back from data memory", i.e. a load.
    localparam logic [1:0] WDSEL_MEM_LOAD = 2'b01;

    // Load-use stall FSM.
    typedef enum logic [0:0] {
        StIdle,
        StLoadStall
    } state_e;

    // Per-cycle action, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        ActBranch,  // MEM-stage redirect flushes younger stages
        ActFreeze,  // data memory not ready, hold everything before MEM_WB
        ActStall,   // load-use bubble into ID_EX
        ActNone     // normal advance
    } action_e;

endpackage

// File: rtl/hazard_match.sv
// Compares the ID-stage sources against one later stage's destination and flags
// a load-use dependence.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned          REG_ADDR_W = 5,
    parameter int unsigned          WDSEL_W    = 2,
    parameter logic [WDSEL_W-1:0]   WDSEL_MEM  = WDSEL_W'(WDSEL_MEM_LOAD)
) (
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [WDSEL_W-1:0]    wdsel_i,
    output logic                  match_o
);

    // x0 never carries a dependence; only loads need a bubble.
    always_comb begin
        match_o = 1'b0;
        if (wdsel_i == WDSEL_MEM && rd_i != '0) begin
            match_o = (rs1_used_i && rs1_i == rd_i) || (rs2_used_i && rs2_i == rd_i);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles of configurable length,
// MEM-stage branch flushes and data-memory wait freezing with a sticky watchdog.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned          REG_ADDR_W   = 5,
    parameter int unsigned          WDSEL_W      = 2,
    parameter logic [WDSEL_W-1:0]   WDSEL_MEM    = WDSEL_W'(WDSEL_MEM_LOAD),
    parameter int unsigned          LOAD_LAT     = 1,
    parameter int unsigned          MEM_WAIT_MAX = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic                  IF_ID_rs1_used,
    input  logic                  IF_ID_rs2_used,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic [WDSEL_W-1:0]    ID_EX_WDSel,
    input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
    input  logic [WDSEL_W-1:0]    EX_MEM_WDSel,
    input  logic                  MEM_branch_taken,
    input  logic                  MEM_mem_req,
    input  logic                  MEM_mem_ready,
    output logic                  PC_we,
    output logic                  IF_ID_we,
    output logic                  ID_EX_we,
    output logic                  EX_MEM_we,
    output logic                  MEM_WB_we,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_flush,
    output logic                  MEM_WB_flush,
    output logic                  stall_active,
    output logic                  mem_timeout
);

    localparam int unsigned       CNT_W     = $clog2(LOAD_LAT + 1);
    localparam int unsigned       WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]  NEED_EX   = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0]  NEED_MEM  = CNT_W'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_WAIT_MAX);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic                ex_match, mem_match;
    logic [CNT_W-1:0]    need;
    action_e             action;

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .WDSEL_W    (WDSEL_W),
        .WDSEL_MEM  (WDSEL_MEM)
    ) u_match_ex (
        .rs1_i      (IF_ID_rs1),
        .rs2_i      (IF_ID_rs2),
        .rs1_used_i (IF_ID_rs1_used),
        .rs2_used_i (IF_ID_rs2_used),
        .rd_i       (ID_EX_rd),
        .wdsel_i    (ID_EX_WDSel),
        .match_o    (ex_match)
    );

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .WDSEL_W    (WDSEL_W),
        .WDSEL_MEM  (WDSEL_MEM)
    ) u_match_mem (
        .rs1_i      (IF_ID_rs1),
        .rs2_i      (IF_ID_rs2),
        .rs1_used_i (IF_ID_rs1_used),
        .rs2_used_i (IF_ID_rs2_used),
        .rd_i       (EX_MEM_rd),
        .wdsel_i    (EX_MEM_WDSel),
        .match_o    (mem_match)
    );

    // Bubbles still owed: a load in MEM is one cycle closer than a load in EX.
    always_comb begin
        need = '0;
        if (ex_match) begin
            need = NEED_EX;
        end else if (LOAD_LAT >= 2 && mem_match) begin
            need = NEED_MEM;
        end
    end

    // Pick the single highest-priority action for this cycle.
    always_comb begin
        action = ActNone;
        if (rst) begin
            action = ActNone;
        end else if (MEM_branch_taken) begin
            action = ActBranch;
        end else if (MEM_mem_req && !MEM_mem_ready) begin
            action = ActFreeze;
        end else if (state_q == StLoadStall || need != '0) begin
            action = ActStall;
        end
    end

    // FSM next state and pipeline control outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_we        = 1'b1;
        IF_ID_we     = 1'b1;
        ID_EX_we     = 1'b1;
        EX_MEM_we    = 1'b1;
        MEM_WB_we    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        stall_active = 1'b0;
        unique case (action)
            ActBranch: begin
                // Redirect wins over everything and aborts a pending load stall.
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
                state_d      = StIdle;
                cnt_d        = '0;
            end
            ActFreeze: begin
                // Only the access in MEM is outstanding; drain a bubble into WB.
                PC_we        = 1'b0;
                IF_ID_we     = 1'b0;
                ID_EX_we     = 1'b0;
                EX_MEM_we    = 1'b0;
                MEM_WB_flush = 1'b1;
                stall_active = 1'b1;
            end
            ActStall: begin
                PC_we        = 1'b0;
                IF_ID_we     = 1'b0;
                ID_EX_flush  = 1'b1;
                stall_active = 1'b1;
                if (state_q == StIdle) begin
                    if (need > CNT_W'(1)) begin
                        state_d = StLoadStall;
                        cnt_d   = need - CNT_W'(1);
                    end
                end else begin
                    // Inside a stall the remaining count alone decides; no re-check.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            ActNone: begin
            end
            default: begin
            end
        endcase
    end

    // Saturating dmem wait counter and sticky watchdog; visible in the cycle it trips.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (action == ActFreeze) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
            if (wait_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end
        mem_timeout = !rst && timeout_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: dut_a has LOAD_LAT=3, dut_b has LOAD_LAT=1; both MEM_WAIT_MAX=8.
module tb_hazard_ctrl;

    // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB we, IF_ID,ID_EX,EX_MEM,MEM_WB flush, stall, timeout}
    localparam logic [10:0] NORM = 11'b11111_0000_0_0;
    localparam logic [10:0] LST  = 11'b00111_0100_1_0;
    localparam logic [10:0] BR   = 11'b11111_1110_0_0;
    localparam logic [10:0] FRZ  = 11'b00001_0001_1_0;
    localparam logic [10:0] TO   = 11'b00000_0000_0_1;

    typedef struct {
        string       name;
        logic [10:0] exp_a;
        bit          chk_a;
        logic [10:0] exp_b;
        bit          chk_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
    logic       IF_ID_rs1_used, IF_ID_rs2_used;
    logic [1:0] ID_EX_WDSel, EX_MEM_WDSel;
    logic       MEM_branch_taken, MEM_mem_req, MEM_mem_ready;
    logic [10:0] oa, ob;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .LOAD_LAT     (3),
        .MEM_WAIT_MAX (8)
    ) dut_a (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_rs1        (IF_ID_rs1),
        .IF_ID_rs2        (IF_ID_rs2),
        .IF_ID_rs1_used   (IF_ID_rs1_used),
        .IF_ID_rs2_used   (IF_ID_rs2_used),
        .ID_EX_rd         (ID_EX_rd),
        .ID_EX_WDSel      (ID_EX_WDSel),
        .EX_MEM_rd        (EX_MEM_rd),
        .EX_MEM_WDSel     (EX_MEM_WDSel),
        .MEM_branch_taken (MEM_branch_taken),
        .MEM_mem_req      (MEM_mem_req),
        .MEM_mem_ready    (MEM_mem_ready),
        .PC_we            (oa[10]),
        .IF_ID_we         (oa[9]),
        .ID_EX_we         (oa[8]),
        .EX_MEM_we        (oa[7]),
        .MEM_WB_we        (oa[6]),
        .IF_ID_flush      (oa[5]),
        .ID_EX_flush      (oa[4]),
        .EX_MEM_flush     (oa[3]),
        .MEM_WB_flush     (oa[2]),
        .stall_active     (oa[1]),
        .mem_timeout      (oa[0])
    );

    hazard_ctrl #(
        .LOAD_LAT     (1),
        .MEM_WAIT_MAX (8)
    ) dut_b (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_rs1        (IF_ID_rs1),
        .IF_ID_rs2        (IF_ID_rs2),
        .IF_ID_rs1_used   (IF_ID_rs1_used),
        .IF_ID_rs2_used   (IF_ID_rs2_used),
        .ID_EX_rd         (ID_EX_rd),
        .ID_EX_WDSel      (ID_EX_WDSel),
        .EX_MEM_rd        (EX_MEM_rd),
        .EX_MEM_WDSel     (EX_MEM_WDSel),
        .MEM_branch_taken (MEM_branch_taken),
        .MEM_mem_req      (MEM_mem_req),
        .MEM_mem_ready    (MEM_mem_ready),
        .PC_we            (ob[10]),
        .IF_ID_we         (ob[9]),
        .ID_EX_we         (ob[8]),
        .EX_MEM_we        (ob[7]),
        .MEM_WB_we        (ob[6]),
        .IF_ID_flush      (ob[5]),
        .ID_EX_flush      (ob[4]),
        .EX_MEM_flush     (ob[3]),
        .MEM_WB_flush     (ob[2]),
        .stall_active     (ob[1]),
        .mem_timeout      (ob[0])
    );

    // Monitor: outputs are combinational, so every cycle presents one result.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_a) begin
                checks++;
                if (oa !== e.exp_a) begin
                    errors++;
                    $display("FAIL %s lat3: got %b want %b", e.name, oa, e.exp_a);
                end
            end
            if (e.chk_b) begin
                checks++;
                if (ob !== e.exp_b) begin
                    errors++;
                    $display("FAIL %s lat1: got %b want %b", e.name, ob, e.exp_b);
                end
            end
        end
    end

    task automatic step(input string name, input logic [10:0] ea, input bit ca,
                        input logic [10:0] eb, input bit cb);
        exp_t e;
        e.name  = name;
        e.exp_a = ea;
        e.chk_a = ca;
        e.exp_b = eb;
        e.chk_b = cb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_rs1_used = 1'b0; IF_ID_rs2_used = 1'b0;
        ID_EX_rd = '0; ID_EX_WDSel = '0; EX_MEM_rd = '0; EX_MEM_WDSel = '0;
        MEM_branch_taken = 1'b0; MEM_mem_req = 1'b0; MEM_mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step("reset", NORM, 1, NORM, 1);
        rst = 1'b0;
    endtask

    // EX holds a load to rd 7 that the ID instruction reads through rs2.
    task automatic ex_load_rs2_7();
        ID_EX_rd = 5'd7; ID_EX_WDSel = 2'b01; IF_ID_rs2 = 5'd7; IF_ID_rs2_used = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        step("reset_init", NORM, 1, NORM, 1);
        rst = 1'b0;

        // Single-bubble load-use; a load in MEM costs nothing at LOAD_LAT=1.
        ID_EX_rd = 5'd5; ID_EX_WDSel = 2'b01; IF_ID_rs1 = 5'd5; IF_ID_rs1_used = 1'b1;
        step("l1_stall", LST, 1, LST, 1);
        ID_EX_rd = '0; ID_EX_WDSel = '0; EX_MEM_rd = 5'd5; EX_MEM_WDSel = 2'b01;
        step("l1_release", LST, 1, NORM, 1);
        do_reset();

        // EX match at LOAD_LAT=3: three bubbles, inputs cleared after the first.
        ex_load_rs2_7();
        step("ex_stall1", LST, 1, LST, 1);
        clear_inputs();
        step("ex_stall2", LST, 1, NORM, 1);
        step("ex_stall3", LST, 1, NORM, 1);
        step("ex_done", NORM, 1, NORM, 1);

        // MEM match only: two bubbles.
        EX_MEM_rd = 5'd7; EX_MEM_WDSel = 2'b01; IF_ID_rs2 = 5'd7; IF_ID_rs2_used = 1'b1;
        step("mem_stall1", LST, 1, NORM, 1);
        clear_inputs();
        step("mem_stall2", LST, 1, NORM, 1);
        step("mem_done", NORM, 1, NORM, 1);

        // Non-hazards: rd=0, source unused, producer not a load.
        ID_EX_rd = '0; ID_EX_WDSel = 2'b01; IF_ID_rs2 = '0; IF_ID_rs2_used = 1'b1;
        step("rd_zero", NORM, 1, NORM, 1);
        ID_EX_rd = 5'd7; IF_ID_rs2 = 5'd7; IF_ID_rs2_used = 1'b0;
        step("rs2_unused", NORM, 1, NORM, 1);
        ID_EX_WDSel = 2'b00; IF_ID_rs1 = 5'd7; IF_ID_rs1_used = 1'b1;
        step("not_load", NORM, 1, NORM, 1);
        clear_inputs();

        // Branch in the second stall cycle aborts the stall.
        ex_load_rs2_7();
        step("br_stall1", LST, 1, LST, 1);
        clear_inputs();
        MEM_branch_taken = 1'b1;
        step("br_flush", BR, 1, BR, 1);
        MEM_branch_taken = 1'b0;
        step("br_after1", NORM, 1, NORM, 1);
        step("br_after2", NORM, 1, NORM, 1);

        // Branch outranks a dmem wait.
        MEM_branch_taken = 1'b1; MEM_mem_req = 1'b1;
        step("br_over_frz", BR, 1, BR, 1);
        clear_inputs();

        // Freeze arriving mid-stall holds the stall count.
        ex_load_rs2_7();
        step("frz_stall1", LST, 1, LST, 1);
        clear_inputs();
        MEM_mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("frz_hold", FRZ, 1, FRZ, 1);
        MEM_mem_ready = 1'b1;
        step("frz_resume2", LST, 1, NORM, 1);
        MEM_mem_req = 1'b0; MEM_mem_ready = 1'b0;
        step("frz_resume3", LST, 1, NORM, 1);
        step("frz_done", NORM, 1, NORM, 1);

        // Watchdog trips on the 8th consecutive wait cycle and sticks.
        MEM_mem_req = 1'b1;
        for (int i = 0; i < 7; i++) step("wait_pre", FRZ, 1, FRZ, 1);
        step("wait_trip", FRZ | TO, 1, FRZ | TO, 1);
        step("wait_sat", FRZ | TO, 1, FRZ | TO, 1);
        MEM_mem_ready = 1'b1;
        step("to_sticky1", NORM | TO, 1, NORM | TO, 1);
        MEM_mem_req = 1'b0; MEM_mem_ready = 1'b0;
        step("to_sticky2", NORM | TO, 1, NORM | TO, 1);
        do_reset();
        step("to_cleared", NORM, 1, NORM, 1);

        // Reset in the middle of a load stall leaves nothing behind.
        ex_load_rs2_7();
        step("rst_stall1", LST, 1, LST, 1);
        clear_inputs();
        step("rst_stall2", LST, 1, NORM, 1);
        do_reset();
        step("rst_after", NORM, 1, NORM, 1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32 core with MEM-stage branch resolution. It generalises single-cycle load-use stalling to a configurable load latency (multi-cycle bubbles tracked by a counter). It adds MEM-stage control-hazard flushing and data-memory wait freezing with a timeout watchdog. It drives write-enables and flushes for every pipeline register and the PC.

Parameters:
REG_ADDR_W, 5, register index width
WDSEL_W, 2, width of write-back select field
WDSEL_MEM, 2'b01, WDSel code meaning "write-back from data memory" (load)
LOAD_LAT, 1, bubbles required between a load in EX and a dependent instruction in ID (>=1)
MEM_WAIT_MAX, 64, consecutive dmem wait cycles before mem_timeout sets (>=1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
IF_ID_rs1  in  REG_ADDR_W  rs1 of instruction in ID
IF_ID_rs2  in  REG_ADDR_W  rs2 of instruction in ID
IF_ID_rs1_used  in  1  ID instruction reads rs1
IF_ID_rs2_used  in  1  ID instruction reads rs2
ID_EX_rd  in  REG_ADDR_W  rd of instruction in EX
ID_EX_WDSel  in  WDSEL_W  WDSel of instruction in EX
EX_MEM_rd  in  REG_ADDR_W  rd of instruction in MEM
EX_MEM_WDSel  in  WDSEL_W  WDSel of instruction in MEM
MEM_branch_taken  in  1  branch/jump resolved taken in MEM
MEM_mem_req  in  1  MEM stage is accessing data memory
MEM_mem_ready  in  1  data memory completes access this cycle
PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we  out  1 each  register write-enables
IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load bubble (NOP) into register
stall_active  out  1  FSM in LOAD_STALL or any stall/freeze this cycle
mem_timeout  out  1  sticky watchdog error

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on rst.
- While rst=1: all *_we=1, all *_flush=0, stall_active=0. FSM goes to IDLE, stall counter and wait counter go to 0, mem_timeout goes to 0.
- Outputs are combinational from registered state plus current inputs. State updates on posedge clk.
- Match rule: src matches a stage when src_used=1, src==stage_rd, stage_rd!=0 and stage_WDSel==WDSEL_MEM.
- need: LOAD_LAT if ID_EX matches; else LOAD_LAT-1 if LOAD_LAT>=2 and EX_MEM matches; else 0.
- FSM states: IDLE, LOAD_STALL. Counter width is $clog2(LOAD_LAT+1).
- Priority per cycle is 1 (highest) to 4:
  1. MEM_branch_taken=1: flush the younger stages.
     - PC_we=1, all we=1.
     - IF_ID_flush=ID_EX_flush=EX_MEM_flush=1, MEM_WB_flush=0.
     - FSM goes to IDLE and the counter clears, aborting any load stall.
     - Wait counter clears.
  2. MEM_mem_req=1 and MEM_mem_ready=0: freeze the pipeline.
     - PC_we=IF_ID_we=ID_EX_we=EX_MEM_we=0, MEM_WB_we=1, MEM_WB_flush=1, other flushes=0.
     - FSM state and counter hold.
     - Wait counter increments and saturates. When it reaches MEM_WAIT_MAX, mem_timeout sets and stays set until rst. The freeze continues regardless.
  3. Otherwise the wait counter clears.
  4. Load-use stall, when FSM is LOAD_STALL, or FSM is IDLE with need>0:
     - PC_we=0, IF_ID_we=0, ID_EX_flush=1, other we=1, other flushes=0.
     - IDLE with need>1: go to LOAD_STALL with cnt=need-1.
     - LOAD_STALL: cnt decrements. When cnt==1, next state is IDLE.
     - Hazards are not re-evaluated inside LOAD_STALL.
  5. Else: all we=1, all flush=0.
- stall_active=1 whenever case 2 or case 4 applies.
- LOAD_LAT=1 gives a single bubble per load-use, purely combinational, with the FSM never leaving IDLE.

Decomposition:
- Package hazard_pkg holds the WDSEL_MEM code, the state enum (IDLE, LOAD_STALL) and the priority constants.
- One natural sub-module, hazard_match: combinational rd/rs comparison producing per-stage match bits. It is instantiated for ID_EX and EX_MEM.

Test Plan:
- LOAD_LAT=1, EX load rd=5 (WDSel=01), ID rs1=5 used -> PC_we=0, IF_ID_we=0, ID_EX_flush=1 for exactly 1 cycle, then all we=1.
- LOAD_LAT=3, EX load rd=7, ID rs2=7 -> 3 consecutive stall cycles. Same with EX_MEM load rd=7 and no EX match -> 2 cycles. rd=0 or rs2_used=0 -> 0 cycles.
- LOAD_LAT=3, MEM_branch_taken=1 in the 2nd stall cycle -> that cycle IF_ID/ID_EX/EX_MEM_flush=1 with PC_we=1, FSM in IDLE next cycle, no further stall.
- MEM_mem_req=1, mem_ready=0 for 4 cycles arriving mid LOAD_STALL -> 4 freeze cycles (PC/IF_ID/ID_EX/EX_MEM we=0, MEM_WB_flush=1), counter held, remaining stall cycles resume after ready.
- MEM_WAIT_MAX=8, mem_ready held 0 for 8 cycles -> mem_timeout=1 from the 8th cycle on, stays 1 after ready. rst=1 for 1 cycle -> mem_timeout=0, all we=1.
- rst asserted mid LOAD_STALL -> next cycle FSM in IDLE, no residual stall without a new hazard.
